ccu_jump_seq: RTL and testbench

Parametrised jump-order sequencer for the control section. It generalises the fixed two-order jump logic to NUM_COND conditional jumps plus one unconditional jump, each with its own sign polarity. It performs the accumulator sign test itself at a configurable digit position and issues the SCT-suppress and end-pulse handshakes. It adds busy/error reporting and an end-pulse retry limit, and sits between order decode/MCU stimulus (s2) and the accumulator, SCT and end-pulse logic.

---
 rtl/ccu_pkg.sv | 28 ++
 rtl/ccu_digit_strobe.sv | 34 +++
 rtl/ccu_jump_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_ccu_jump_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ccu_pkg                                                      |
// | Description : Shared types and constants for the CCU jump-order sequencer. |
// |               Holds the sequencer state encoding, the conditional order    |
// |               bit indices and the default per-order jump polarity.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ccu_pkg;

    // Sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        WAIT_EV = 2'd2,
        END     = 2'd3
    } ccu_state_e;

    // Bit positions of the conditional orders in order_cond.
    localparam int ORD_E = 0;
    localparam int ORD_G = 1;

    // Polarity per conditional order: 1 = jump on acc >= 0, 0 = jump on acc < 0.
    // E jumps on a non-negative accumulator, G on a negative one.
    localparam logic [1:0] COND_POL_DEFAULT = 2'b01;

endpackage : ccu_pkg
`default_nettype wire

// File: rtl/ccu_digit_strobe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ccu_digit_strobe                                             |
// | Description : Decodes one fixed digit position into separate odd-cycle and |
// |               even-cycle strobes.                                          |
// | Ports       : digit    (in)  current digit position from timing unit       |
// |               odd      (in)  1 = odd minor cycle                           |
// |               odd_hit  (out) digit == DIG during an odd minor cycle        |
// |               even_hit (out) digit == DIG during an even minor cycle       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ccu_digit_strobe
    import ccu_pkg::*;
#(
    parameter int DIGITS = 36,
    parameter int DIG    = 0
) (
    input  logic [$clog2(DIGITS)-1:0] digit,
    input  logic                      odd,
    output logic                      odd_hit,
    output logic                      even_hit
);

    localparam int                c_DW  = $clog2(DIGITS);
    localparam logic [c_DW-1:0]   c_DIG = c_DW'(DIG);

    logic w_match;

    assign w_match  = (digit == c_DIG);
    assign odd_hit  = w_match & odd;
    assign even_hit = w_match & ~odd;

endmodule : ccu_digit_strobe
`default_nettype wire

// File: rtl/ccu_jump_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ccu_jump_seq                                                 |
// | Description : Jump-order sequencer for the control section. Accepts        |
// |               NUM_COND conditional jump orders plus one unconditional      |
// |               jump, strobes the accumulator sign test, decides the jump,   |
// |               suppresses the SCT increment for a taken jump and issues     |
// |               end pulses until acknowledged or the retry limit is hit.     |
// | Ports       : clk          (in)  system clock                              |
// |               rst          (in)  asynchronous active-high reset            |
// |               s2           (in)  one-cycle stimulating pulse from MCU      |
// |               order_cond   (in)  decoded conditional jump orders           |
// |               op_j         (in)  unconditional jump opcode decode          |
// |               extended_pos (in)  qualifier for the unconditional jump      |
// |               digit        (in)  current digit position                    |
// |               odd          (in)  1 = odd minor cycle                       |
// |               acc_sign     (in)  accumulator sign, valid on dv cycle       |
// |               ep_done      (in)  end-pulse acknowledge                     |
// |               dv           (out) sign-test strobe to accumulator           |
// |               jump_uc      (out) op_j & extended_pos                       |
// |               jump_taken   (out) registered jump decision                  |
// |               stop_one_b   (out) suppress SCT increment                    |
// |               ep5          (out) end pulse for transfer                    |
// |               busy         (out) sequencer not idle                        |
// |               order_err    (out) one-cycle error pulse                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ccu_jump_seq
    import ccu_pkg::*;
#(
    parameter int                  NUM_COND   = 2,
    parameter logic [NUM_COND-1:0] COND_POL   = NUM_COND'(COND_POL_DEFAULT),
    parameter int                  DIGITS     = 36,
    parameter int                  SIGN_DIGIT = 35,
    parameter int                  END_DIGIT  = 0,
    parameter int                  MAX_EP5    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s2,
    input  logic [NUM_COND-1:0]       order_cond,
    input  logic                      op_j,
    input  logic                      extended_pos,
    input  logic [$clog2(DIGITS)-1:0] digit,
    input  logic                      odd,
    input  logic                      acc_sign,
    input  logic                      ep_done,
    output logic                      dv,
    output logic                      jump_uc,
    output logic                      jump_taken,
    output logic                      stop_one_b,
    output logic                      ep5,
    output logic                      busy,
    output logic                      order_err
);

    localparam int              c_IW  = (NUM_COND > 1) ? $clog2(NUM_COND) : 1;
    localparam int              c_CW  = $clog2(MAX_EP5 + 1);
    localparam logic [c_CW-1:0] c_MAX = c_CW'(MAX_EP5);

    // ------------------------------------------------------------------
    // Digit strobes
    // ------------------------------------------------------------------
    logic w_sig_stb;
    logic w_unused_sig_even;
    logic w_od_end;
    logic w_ev_end;

    ccu_digit_strobe #(
        .DIGITS (DIGITS),
        .DIG    (SIGN_DIGIT)
    ) u_sign_strobe (
        .digit    (digit),
        .odd      (odd),
        .odd_hit  (w_sig_stb),
        .even_hit (w_unused_sig_even)
    );

    ccu_digit_strobe #(
        .DIGITS (DIGITS),
        .DIG    (END_DIGIT)
    ) u_end_strobe (
        .digit    (digit),
        .odd      (odd),
        .odd_hit  (w_od_end),
        .even_hit (w_ev_end)
    );

    // ------------------------------------------------------------------
    // Order decode
    // ------------------------------------------------------------------
    logic            w_any_order;
    logic            w_multi_order;
    logic [c_IW-1:0] w_cond_idx;

    assign jump_uc     = op_j & extended_pos;
    assign w_any_order = jump_uc | (|order_cond);

    // x & (x-1) is non-zero exactly when two or more bits of x are set.
    assign w_multi_order = (|(order_cond & (order_cond - NUM_COND'(1))))
                         | (jump_uc & (|order_cond));

    // Lowest set index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        w_cond_idx = '0;
        for (int i = NUM_COND - 1; i >= 0; i--) begin
            if (order_cond[i]) begin
                w_cond_idx = c_IW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    ccu_state_e      r_state;
    ccu_state_e      w_state_nxt;
    logic            r_uc;
    logic [c_IW-1:0] r_idx;
    logic            r_jump_taken;
    logic [c_CW-1:0] r_ep_cnt;
    logic            r_order_err;

    logic w_latch;
    logic w_sample;
    logic w_clear;
    logic w_err;

    always_comb begin
        w_state_nxt = r_state;
        dv          = 1'b0;
        stop_one_b  = 1'b0;
        ep5         = 1'b0;
        w_latch     = 1'b0;
        w_sample    = 1'b0;
        w_clear     = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            IDLE: begin
                // s2 is broadcast; without an order bit it belongs elsewhere.
                if (s2 && w_any_order) begin
                    w_latch     = 1'b1;
                    w_err       = w_multi_order;
                    w_state_nxt = ARM;
                end
            end

            ARM: begin
                w_err = s2;
                if (w_sig_stb) begin
                    dv          = 1'b1;
                    w_sample    = 1'b1;
                    w_state_nxt = WAIT_EV;
                end
            end

            WAIT_EV: begin
                w_err      = s2;
                stop_one_b = r_jump_taken;
                if (w_ev_end) begin
                    w_state_nxt = END;
                end
            end

            END: begin
                w_err      = s2;
                stop_one_b = r_jump_taken;
                // Once the retry budget is spent no further pulse is issued.
                if (w_od_end && (r_ep_cnt < c_MAX)) begin
                    ep5 = 1'b1;
                end
                if (ep_done) begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_od_end && (r_ep_cnt == c_MAX)) begin
                    w_err       = 1'b1;
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_uc         <= 1'b0;
            r_idx        <= '0;
            r_jump_taken <= 1'b0;
            r_ep_cnt     <= '0;
            r_order_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_order_err <= w_err;

            if (w_latch) begin
                r_uc  <= jump_uc;
                r_idx <= w_cond_idx;
            end

            if (w_clear) begin
                r_jump_taken <= 1'b0;
            end else if (w_sample) begin
                r_jump_taken <= r_uc | (COND_POL[r_idx] ? ~acc_sign : acc_sign);
            end

            // Saturating pulse counter; ep5 is already gated at c_MAX.
            if (w_clear) begin
                r_ep_cnt <= '0;
            end else if (ep5 && (r_ep_cnt < c_MAX)) begin
                r_ep_cnt <= r_ep_cnt + c_CW'(1);
            end
        end
    end

    assign jump_taken = r_jump_taken;
    assign busy       = (r_state != IDLE);
    assign order_err  = r_order_err;

endmodule : ccu_jump_seq
`default_nettype wire

// File: tb/tb_ccu_jump_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ccu_jump_seq                                              |
// | Description : Scoreboard bench for ccu_jump_seq. Directed stimulus pushes  |
// |               expected dv / ep5 / order_err events into a queue; a monitor |
// |               pops and compares each event the DUT presents.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ccu_jump_seq;

    localparam int c_DIGITS = 36;
    localparam int K_DV     = 0;
    localparam int K_EP5    = 1;
    localparam int K_ERR    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       s2;
    logic [1:0] order_cond;
    logic       op_j;
    logic       extended_pos;
    logic [5:0] digit;
    logic       odd;
    logic       acc_sign;
    logic       ep_done;
    logic       dv;
    logic       jump_uc;
    logic       jump_taken;
    logic       stop_one_b;
    logic       ep5;
    logic       busy;
    logic       order_err;

    int n_checks = 0;
    int n_errors = 0;
    int ev_idx   = 0;

    typedef struct {
        int         kind;
        logic [5:0] dig;
        logic       odd;
        bit         chk_pos;
        logic       jt;
        logic       sob;
        logic       busy;
    } ev_t;

    ev_t exp_q[$];

    ccu_jump_seq #(
        .NUM_COND   (2),
        .COND_POL   (2'b01),
        .DIGITS     (36),
        .SIGN_DIGIT (35),
        .END_DIGIT  (0),
        .MAX_EP5    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s2           (s2),
        .order_cond   (order_cond),
        .op_j         (op_j),
        .extended_pos (extended_pos),
        .digit        (digit),
        .odd          (odd),
        .acc_sign     (acc_sign),
        .ep_done      (ep_done),
        .dv           (dv),
        .jump_uc      (jump_uc),
        .jump_taken   (jump_taken),
        .stop_one_b   (stop_one_b),
        .ep5          (ep5),
        .busy         (busy),
        .order_err    (order_err)
    );

    always #5 clk = ~clk;

    // Free-running digit timing: advances 1 ns after each rising edge.
    initial begin
        digit = 6'd0;
        odd   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (digit == 6'(c_DIGITS - 1)) begin
                digit = 6'd0;
                odd   = ~odd;
            end else begin
                digit = digit + 6'd1;
            end
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired, got no event expected one", name);
    endfunction

    function automatic void push_dv();
        exp_q.push_back('{K_DV, 6'd35, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    endfunction

    function automatic void push_ep5(input logic jt);
        exp_q.push_back('{K_EP5, 6'd0, 1'b1, 1'b1, jt, jt, 1'b1});
    endfunction

    function automatic void push_err(input logic bsy);
        exp_q.push_back('{K_ERR, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, bsy});
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    task automatic mon_event(input int kind);
        ev_t e;
        ev_idx++;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event_%0d: got kind=%0d d=%0d odd=%0b, expected no event",
                     ev_idx, kind, digit, odd);
            return;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (kind != e.kind || (e.chk_pos && (digit !== e.dig || odd !== e.odd)) ||
            jump_taken !== e.jt || stop_one_b !== e.sob || busy !== e.busy) begin
            n_errors++;
            $display("FAIL event_%0d: got kind=%0d d=%0d odd=%0b jt=%0b sob=%0b busy=%0b, expected kind=%0d d=%0d odd=%0b jt=%0b sob=%0b busy=%0b",
                     ev_idx, kind, digit, odd, jump_taken, stop_one_b, busy,
                     e.kind, e.dig, e.odd, e.jt, e.sob, e.busy);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (order_err === 1'b1) mon_event(K_ERR);
                if (dv === 1'b1)        mon_event(K_DV);
                if (ep5 === 1'b1)       mon_event(K_EP5);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 ns after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pos(input logic [5:0] d, input logic o);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(digit == d && odd == o) && n < 200);
        if (n >= 200) fail_timeout("wait_pos");
    endtask

    task automatic start_order(input logic [1:0] oc, input logic sgn);
        wait_pos(6'd10, 1'b0);
        order_cond = oc;
        acc_sign   = sgn;
        s2         = 1'b1;
        tick();
        s2         = 1'b0;
        order_cond = 2'b00;
    endtask

    task automatic finish_ep(input string name);
        int n = 0;
        while (ep5 !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) fail_timeout({name, "_ep5"});
        ep_done = 1'b1;
        tick();
        ep_done = 1'b0;
        check({name, "_idle"}, {busy, jump_taken, stop_one_b, ep5, dv, order_err}, 6'b0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        rst          = 1'b1;
        s2           = 1'b0;
        order_cond   = 2'b00;
        op_j         = 1'b1;
        extended_pos = 1'b1;
        acc_sign     = 1'b0;
        ep_done      = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", {dv, jump_taken, stop_one_b, ep5, busy, order_err}, 6'b0);
        check("reset_jump_uc", jump_uc, 1);
        op_j         = 1'b0;
        extended_pos = 1'b0;
        #1;
        check("jump_uc_low", jump_uc, 0);
        rst = 1'b0;
        tick();

        // E order, acc >= 0 -> taken
        push_dv(); push_ep5(1'b1);
        start_order(2'b01, 1'b0);
        finish_ep("e_pos");

        // G order, acc >= 0 -> not taken, ep5 still issued
        push_dv(); push_ep5(1'b0);
        start_order(2'b10, 1'b0);
        finish_ep("g_pos");

        // G order, acc < 0 -> taken
        push_dv(); push_ep5(1'b1);
        start_order(2'b10, 1'b1);
        finish_ep("g_neg");

        // Unconditional jump, taken regardless of negative sign
        push_dv(); push_ep5(1'b1);
        wait_pos(6'd10, 1'b0);
        op_j         = 1'b1;
        extended_pos = 1'b1;
        acc_sign     = 1'b1;
        #1;
        check("uc_comb", jump_uc, 1);
        s2 = 1'b1;
        tick();
        s2           = 1'b0;
        op_j         = 1'b0;
        extended_pos = 1'b0;
        finish_ep("uc");

        // op_j without qualifier and no order: nothing happens
        wait_pos(6'd10, 1'b0);
        op_j         = 1'b1;
        extended_pos = 1'b0;
        #1;
        check("uc_qual_low", jump_uc, 0);
        s2 = 1'b1;
        tick();
        s2   = 1'b0;
        op_j = 1'b0;
        repeat (80) tick();
        check("uc_qual_idle", busy, 0);

        // Both orders: E wins (taken at acc >= 0) and order_err pulses
        push_err(1'b1); push_dv(); push_ep5(1'b1);
        start_order(2'b11, 1'b0);
        finish_ep("conflict");

        // s2 while armed: error pulse, original E order (not taken at acc < 0) kept
        push_err(1'b1); push_dv(); push_ep5(1'b0);
        start_order(2'b01, 1'b1);
        tick();
        order_cond = 2'b10;
        s2         = 1'b1;
        tick();
        s2         = 1'b0;
        order_cond = 2'b00;
        finish_ep("busy_s2");

        // s2 exactly on the sign strobe waits a full word pair
        push_dv(); push_ep5(1'b1);
        wait_pos(6'd35, 1'b1);
        order_cond = 2'b01;
        acc_sign   = 1'b0;
        s2         = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                s2         = 1'b0;
                order_cond = 2'b00;
            end
        end while (dv !== 1'b1 && n < 200);
        check("s2_on_sig_latency", n, 72);
        finish_ep("late_dv");

        // ep_done withheld: four pulses, then error and return to idle
        push_dv(); repeat (4) push_ep5(1'b1); push_err(1'b0);
        start_order(2'b01, 1'b0);
        n = 0;
        while (order_err !== 1'b1 && n < 800) begin
            tick();
            n++;
        end
        if (n >= 800) fail_timeout("timeout_err");
        check("timeout_idle", {busy, jump_taken, stop_one_b}, 3'b000);
        repeat (3) tick();

        // Reset while ep5 is high
        push_dv();
        start_order(2'b01, 1'b0);
        n = 0;
        while (ep5 !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) fail_timeout("reset_ep5");
        rst = 1'b1;
        #1;
        check("async_reset", {ep5, stop_one_b, busy, jump_taken}, 4'b0000);
        tick();
        tick();
        rst = 1'b0;

        // Fresh order after reset behaves normally
        push_dv(); push_ep5(1'b1);
        start_order(2'b10, 1'b1);
        finish_ep("post_reset");

        repeat (5) tick();
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_ccu_jump_seq
`default_nettype wire
